rhd_spi_command_tx: RTL and testbench

Master-side SPI frame engine for the RHD2000 headstage link, running on `dataclk` at 4× the SPI bit rate. It accepts 16-bit commands over a ready/valid handshake and drives `CS_b`, `SCLK` and `MOSI`. During each frame it samples `MISO` on every `dataclk` edge into a 74-bit vector, `MISO4x`, which feeds the downstream MISO phase-select/downsample logic. The vector includes a 10-sample tail that covers up to 10 cycles of cable delay.

---
 rtl/rhd_spi_command_tx.sv | 137 +++++++++++++
 tb/tb_rhd_spi_command_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhd_spi_command_tx.sv
// rhd_spi_command_tx: SPI master frame engine for the RHD2000 link.
// Runs at 4x the SPI bit rate, sends one 16-bit command per 64-cycle
// frame and captures MISO on every clock into a 74-sample vector.
// The vector includes a 10-sample tail that absorbs cable delay.
module rhd_spi_command_tx #(
  parameter int CS_HIGH_CYCLES = 12
) (
  input  logic        dataclk,
  input  logic        reset,
  input  logic [15:0] cmd,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        CS_b,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [73:0] MISO4x,
  output logic        MISO4x_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] GAP_LAST = 8'(CS_HIGH_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [7:0]  g_reg, g_next;
  logic [15:0] cmd_reg, cmd_next;

  logic        cs_b_next, sclk_next, mosi_next, cmd_ready_next, busy_next;

  // Samples 0..72; sample 73 is taken straight from MISO on the copy edge.
  logic [72:0] samples_reg;
  logic [6:0]  tail_idx;
  logic        accept;

  assign accept   = cmd_valid && cmd_ready;
  assign tail_idx = 7'd64 + {3'd0, g_reg[3:0]};

  // State, counters, latched command and registered pin outputs.
  always_ff @(posedge dataclk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      g_reg     <= '0;
      cmd_reg   <= '0;
      CS_b      <= 1'b1;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      g_reg     <= g_next;
      cmd_reg   <= cmd_next;
      CS_b      <= cs_b_next;
      SCLK      <= sclk_next;
      MOSI      <= mosi_next;
      cmd_ready <= cmd_ready_next;
      busy      <= busy_next;
    end
  end

  // Next-state logic: IDLE -> SHIFT (64 cycles) -> GAP (CS high time),
  // with a direct GAP -> SHIFT hop when a command arrives in the last gap cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    g_next     = g_reg;
    cmd_next   = cmd_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          cnt_next   = '0;
          cmd_next   = cmd;
        end
      end
      SHIFT: begin
        cnt_next = cnt_reg + 6'd1;
        if (cnt_reg == 6'd63) begin
          state_next = GAP;
          g_next     = '0;
        end
      end
      GAP: begin
        g_next = g_reg + 8'd1;
        if (g_reg == GAP_LAST) begin
          g_next = '0;
          if (accept) begin
            state_next = SHIFT;
            cnt_next   = '0;
            cmd_next   = cmd;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every pin is a flop output.
  always_comb begin
    cs_b_next      = (state_next != SHIFT);
    sclk_next      = (state_next == SHIFT) && cnt_next[1];
    mosi_next      = (state_next == SHIFT) && cmd_next[4'd15 - cnt_next[5:2]];
    cmd_ready_next = (state_next == IDLE) ||
                     ((state_next == GAP) && (g_next == GAP_LAST));
    busy_next      = (state_next != IDLE);
  end

  // MISO capture: one sample per cycle through SHIFT and the first ten
  // GAP cycles, then publish the full vector with a one-cycle strobe.
  always_ff @(posedge dataclk) begin
    if (reset) begin
      samples_reg  <= '0;
      MISO4x       <= '0;
      MISO4x_valid <= 1'b0;
    end else begin
      MISO4x_valid <= 1'b0;
      if (state_reg == SHIFT) begin
        samples_reg[cnt_reg] <= MISO;
      end else if (state_reg == GAP && g_reg <= 8'd9) begin
        if (g_reg == 8'd9) begin
          MISO4x       <= {MISO, samples_reg};
          MISO4x_valid <= 1'b1;
        end else begin
          samples_reg[tail_idx] <= MISO;
        end
      end
    end
  end

endmodule

// File: tb/tb_rhd_spi_command_tx.sv
// Testbench for rhd_spi_command_tx: table-driven loopback frames, hand-made
// corner sequences and random traffic, all checked every cycle against a
// timeline model (expected pins as a function of time since acceptance).
module tb_rhd_spi_command_tx;

  localparam int CSH  = 12;
  localparam int MAXC = 16384;

  logic        dataclk = 1'b0;
  logic        reset;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        CS_b, SCLK, MOSI, MISO;
  logic [73:0] MISO4x;
  logic        MISO4x_valid;
  logic        busy;

  always #5 dataclk = ~dataclk;

  rhd_spi_command_tx #(.CS_HIGH_CYCLES(CSH)) dut (
    .dataclk     (dataclk),
    .reset       (reset),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .CS_b        (CS_b),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .MISO4x      (MISO4x),
    .MISO4x_valid(MISO4x_valid),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Histories indexed by cycle number.
  logic        h_miso [MAXC];
  logic        h_cs   [MAXC];
  logic        h_sclk [MAXC];
  logic        h_mosi [MAXC];
  logic [15:0] h_cmd  [MAXC];
  int          dut_valid_q[$];
  int          acc_q[$];

  // Reference model state.
  bit          m_known  = 0;
  bit          m_active = 0;
  int          m_acc    = 0;
  logic [15:0] m_cmd    = '0;
  int          m_pending[$];
  logic [73:0] m_x      = '0;
  bit          e_ready  = 1;

  typedef struct {
    logic [15:0] cmd;
    int          dly;
    logic [15:0] exp_word;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Expected pins in the current cycle from time t since the last acceptance.
  task automatic expect_cycle();
    int   t;
    logic e_cs, e_sclk, e_mosi, e_busy, e_valid;
    t = cyc - m_acc;
    e_cs = 1; e_sclk = 0; e_mosi = 0; e_busy = 0; e_valid = 0;
    e_ready = 1;
    if (m_active && t >= 1 && t <= 64) begin
      e_cs    = 0;
      e_sclk  = (((t - 1) % 4) >= 2);
      e_mosi  = m_cmd[15 - (t - 1) / 4];
      e_busy  = 1;
      e_ready = 0;
    end else if (m_active && t <= 64 + CSH) begin
      e_busy  = 1;
      e_ready = (t == 64 + CSH);
    end else begin
      m_active = 0;
    end
    if (m_pending.size() > 0 && m_pending[0] == cyc) begin
      e_valid = 1;
      for (int n = 0; n < 74; n++) m_x[n] = h_miso[cyc - 74 + n];
      void'(m_pending.pop_front());
    end
    h_cs[cyc]   = CS_b;
    h_sclk[cyc] = SCLK;
    h_mosi[cyc] = MOSI;
    if (MISO4x_valid === 1'b1) dut_valid_q.push_back(cyc);
    if (m_known) begin
      chk("cs_b", CS_b, e_cs);
      chk("sclk", SCLK, e_sclk);
      chk("mosi", MOSI, e_mosi);
      chk("cmd_ready", cmd_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("miso4x_valid", MISO4x_valid, e_valid);
      chk("miso4x", MISO4x, m_x);
      if (cyc > 1 && MOSI !== h_mosi[cyc - 1]) chk("mosi_change_sclk_low", SCLK, 1'b0);
    end
  endtask

  // One clock: drive inputs, advance model across the edge, check outputs.
  // dly < 0 drives random MISO, otherwise MISO is MOSI looped back dly cycles.
  task automatic step(input bit rst, input bit v, input logic [15:0] c, input int dly);
    reset     = rst;
    cmd_valid = v;
    cmd       = c;
    if (dly < 0) MISO = (($urandom % 2) == 1);
    else         MISO = (cyc >= dly && cyc > 0) ? h_mosi[cyc - dly] : 1'b0;
    h_miso[cyc] = MISO;
    h_cmd[cyc]  = c;
    if (rst) begin
      m_active = 0;
      m_pending.delete();
      m_x     = '0;
      m_known = 1;
    end else if (m_known && v && e_ready) begin
      m_active = 1;
      m_acc    = cyc;
      m_cmd    = c;
      m_pending.push_back(cyc + 75);
      acc_q.push_back(cyc);
      $display("accept cyc=%0d cmd=%h", cyc, c);
    end
    @(posedge dataclk);
    #1;
    cyc++;
    expect_cycle();
  endtask

  // Frame statistics from the pin history over cycles a..b.
  task automatic scan(input int a, input int b, output int lows, output int rises,
                      output logic [15:0] word);
    lows = 0; rises = 0; word = '0;
    for (int c = a; c <= b; c++) begin
      if (h_cs[c] === 1'b0) lows++;
      if (c > 0 && h_sclk[c] === 1'b1 && h_sclk[c - 1] === 1'b0) begin
        rises++;
        word = {word[14:0], h_mosi[c]};
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          a, a1, a2, na, vq, k, lows, rises, nhigh;
    logic [15:0] w;

    tbl[0] = '{16'hA5C3, 0,  16'hA5C3};
    tbl[1] = '{16'h1234, 3,  16'h1234};
    tbl[2] = '{16'hFFFF, 5,  16'hFFFF};
    tbl[3] = '{16'h0001, 10, 16'h0001};
    tbl[4] = '{16'h8000, 7,  16'h8000};
    tbl[5] = '{16'h5A5A, 1,  16'h5A5A};

    reset = 1'b1; cmd_valid = 1'b0; cmd = '0; MISO = 1'b0;

    // Reset held three cycles, then released.
    repeat (3) step(1, 0, 16'h0, -1);
    chk("reset_cs_b", CS_b, 1'b1);
    chk("reset_miso4x", MISO4x, 74'd0);
    step(0, 0, 16'h0, -1);
    chk("ready_after_reset", cmd_ready, 1'b1);

    // Table: single frames with MOSI looped back to MISO.
    for (int i = 0; i < 6; i++) begin
      na = acc_q.size();
      vq = dut_valid_q.size();
      step(0, 1, tbl[i].cmd, tbl[i].dly);
      chk("table_accept", acc_q.size(), na + 1);
      if (acc_q.size() == na + 1) begin
        a = acc_q[na];
        repeat (80) step(0, 0, 16'($urandom), tbl[i].dly);
        scan(a, a + 76, lows, rises, w);
        chk("table_cs_low_cycles", lows, 64);
        chk("table_sclk_rises", rises, 16);
        chk("table_mosi_word", w, tbl[i].exp_word);
        for (int b = 0; b < 16; b++) w[15 - b] = MISO4x[tbl[i].dly + 4 * b];
        chk("table_loopback_word", w, tbl[i].exp_word);
        chk("table_valid_pulses", dut_valid_q.size() - vq, 1);
        if (dut_valid_q.size() > vq) chk("table_valid_latency", dut_valid_q[vq] - a, 75);
      end
    end

    // Back-to-back: cmd_valid held high, FFFF then 0000.
    na = acc_q.size(); vq = dut_valid_q.size(); k = 0;
    while (acc_q.size() < na + 2 && k < 300) begin
      step(0, 1, (acc_q.size() == na) ? 16'hFFFF : 16'h0000, -1);
      k++;
    end
    chk("b2b_two_accepts", acc_q.size(), na + 2);
    repeat (90) step(0, 0, 16'h0, -1);
    if (acc_q.size() >= na + 2) begin
      a1 = acc_q[na]; a2 = acc_q[na + 1];
      chk("b2b_accept_spacing", a2 - a1, 64 + CSH);
      nhigh = 0;
      for (int c = a1 + 65; c <= a2 + 1; c++) if (h_cs[c] === 1'b1) nhigh++;
      chk("b2b_cs_high_cycles", nhigh, CSH);
      scan(a1, a1 + 76, lows, rises, w);
      chk("b2b_word1", w, 16'hFFFF);
      scan(a2, a2 + 76, lows, rises, w);
      chk("b2b_word2", w, 16'h0000);
      chk("b2b_valid_pulses", dut_valid_q.size() - vq, 2);
      if (dut_valid_q.size() >= vq + 2)
        chk("b2b_valid_spacing", dut_valid_q[vq + 1] - dut_valid_q[vq], 76);
    end

    // Reset in the middle of a frame (cnt = 30).
    na = acc_q.size();
    step(0, 1, 16'h3C5A, -1);
    chk("midrst_accept", acc_q.size(), na + 1);
    a = m_acc;
    while (cyc - a < 31) step(0, 0, 16'h0, -1);
    vq = dut_valid_q.size();
    step(1, 0, 16'h0, -1);
    chk("midrst_cs_b", CS_b, 1'b1);
    repeat (90) step(0, 0, 16'h0, -1);
    chk("midrst_no_valid", dut_valid_q.size() - vq, 0);
    chk("midrst_miso4x", MISO4x, 74'd0);
    na = acc_q.size(); vq = dut_valid_q.size();
    step(0, 1, 16'h0F0F, 2);
    chk("midrst_next_accept", acc_q.size(), na + 1);
    a = m_acc;
    repeat (80) step(0, 0, 16'h0, 2);
    scan(a, a + 76, lows, rises, w);
    chk("midrst_next_word", w, 16'h0F0F);
    chk("midrst_next_valid", dut_valid_q.size() - vq, 1);

    // Command changing while busy: only the ready-cycle command is taken.
    na = acc_q.size(); k = 0;
    step(0, 1, 16'hC0DE, -1);
    while (acc_q.size() < na + 2 && k < 300) begin
      step(0, 1, 16'($urandom), -1);
      k++;
    end
    chk("busy_two_accepts", acc_q.size(), na + 2);
    repeat (80) step(0, 0, 16'h0, -1);
    if (acc_q.size() >= na + 2) begin
      a1 = acc_q[na]; a2 = acc_q[na + 1];
      chk("busy_accept_spacing", a2 - a1, 64 + CSH);
      scan(a1, a1 + 76, lows, rises, w);
      chk("busy_word1", w, 16'hC0DE);
      scan(a2, a2 + 76, lows, rises, w);
      chk("busy_word2", w, h_cmd[a2]);
    end

    // Random traffic with occasional resets.
    repeat (1500) begin
      k = int'($urandom % 300);
      step(k == 0, ($urandom % 5) == 0, 16'($urandom), -1);
    end
    repeat (90) step(0, 0, 16'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
